// File: rtl/zddr_reader_if.sv
// Bus bundle for zddr_reader: the octal DDR-PSRAM pads and the upload byte stream.
//   master : the reader (drives RAM clock/CE/reset/ADQ/OE and Tx data/valid)
//   slave  : the PSRAM pad + upload consumer (drives read data and Tx ready)
interface zddr_reader_if;
  logic       oRAM_CLK;
  logic       oRAM_CE;
  logic       oRAM_RST;
  logic [7:0] oRAM_ADQ;
  logic       oRAM_ADQ_OE;
  logic [7:0] iRAM_ADQ;
  logic [7:0] oTx_Data;
  logic       oTx_Valid;
  logic       iTx_Ready;

  modport master (
    output oRAM_CLK, oRAM_CE, oRAM_RST, oRAM_ADQ, oRAM_ADQ_OE, oTx_Data, oTx_Valid,
    input  iRAM_ADQ, iTx_Ready
  );

  modport slave (
    input  oRAM_CLK, oRAM_CE, oRAM_RST, oRAM_ADQ, oRAM_ADQ_OE, oTx_Data, oTx_Valid,
    output iRAM_ADQ, iTx_Ready
  );
endinterface

// File: rtl/zddr_reader.sv
// zddr_reader: reads one committed capture frame back from octal DDR-PSRAM with linear
// burst reads, buffers the bytes in a small FIFO and streams them to the upload path.
//   iClk, iRst     : system clock, synchronous active-high reset
//   iStart         : frame-ready pulse (ignored while busy)
//   oBusy          : frame transfer in progress
//   oUpload_Done   : one-cycle pulse once the last byte is accepted downstream
//   bus (master)   : PSRAM pads (CLK = iClk/2, CE/RST active-low, ADQ + OE) and Tx valid/ready
// Optional build macro ZDDR_READER_FRAME_HEADER_EN: wraps the frame as 55,AA, data,
// 16-bit byte sum MSB first.
module zddr_reader #(
  parameter int unsigned FRAME_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned LATENCY     = 5,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned CE_GAP      = 4
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iStart,
  output logic          oBusy,
  output logic          oUpload_Done,
  zddr_reader_if.master bus
);
  localparam int unsigned NumBursts = FRAME_BYTES / BURST_LEN;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FreeThr = CntW'(FIFO_DEPTH - BURST_LEN);
`ifdef ZDDR_READER_FRAME_HEADER_EN
  localparam int unsigned TotalBytes = FRAME_BYTES + 4;
`else
  localparam int unsigned TotalBytes = FRAME_BYTES;
`endif

  typedef enum logic [2:0] {StIdle, StArm, StCmd, StAddr, StWait, StData, StGap, StDrain} state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d, idx_q, idx_d;
  logic            done_q, done_d;
  logic            frame_start, push, pop, load, out_free;
  logic [7:0]      load_byte, fifo_head, addr_byte;
  logic [31:0]     burst_addr;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [15:0]     acc_cnt_q, acc_cnt_d;
  logic            last_acc_q, last_acc_d;
`ifdef ZDDR_READER_FRAME_HEADER_EN
  typedef enum logic [2:0] {OutHdr0, OutHdr1, OutData, OutSumHi, OutSumLo, OutEnd} out_e;
  out_e            phase_q, phase_d;
  logic [15:0]     ld_cnt_q, ld_cnt_d, sum_q, sum_d;
`endif

  // ---------------- read FSM ----------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    idx_d       = idx_q;
    done_d      = 1'b0;
    frame_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (iStart) begin
          frame_start = 1'b1;
          idx_d       = '0;
          state_d     = StArm;
        end
      end
      StArm: begin
        cnt_d = '0;
        // Only open a burst when the whole burst is guaranteed to fit.
        if (fifo_cnt_q <= FreeThr) state_d = StCmd;
      end
      StCmd: if (cnt_q == 16'd1) begin
        cnt_d   = '0;
        state_d = StAddr;
      end
      StAddr: if (cnt_q == 16'd3) begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: if (cnt_q == 16'(2 * LATENCY - 1)) begin
        cnt_d   = '0;
        state_d = StData;
      end
      StData: if (cnt_q == 16'(BURST_LEN - 1)) begin
        cnt_d   = '0;
        state_d = StGap;
      end
      StGap: if (cnt_q == 16'(CE_GAP - 1)) begin
        cnt_d   = '0;
        idx_d   = idx_q + 16'd1;
        state_d = (idx_q + 16'd1 == 16'(NumBursts)) ? StDrain : StArm;
      end
      StDrain: begin
        cnt_d = '0;
        if (last_acc_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // ---------------- PSRAM pad decode ----------------
  assign burst_addr = BASE_ADDR + (32'(idx_q) * BURST_LEN);

  always_comb begin
    addr_byte = 8'h00;
    case (cnt_q[1:0])
      2'd0: addr_byte = burst_addr[31:24];
      2'd1: addr_byte = burst_addr[23:16];
      2'd2: addr_byte = burst_addr[15:8];
      2'd3: addr_byte = burst_addr[7:0];
      default: addr_byte = 8'h00;
    endcase
  end

  logic ram_active;
  assign ram_active      = (state_q == StCmd) || (state_q == StAddr) ||
                           (state_q == StWait) || (state_q == StData);
  // Every phase length is even and cnt_q restarts at each phase, so cnt_q[0] tracks the pair.
  assign bus.oRAM_CLK    = ram_active && !cnt_q[0];
  assign bus.oRAM_CE     = !ram_active;
  assign bus.oRAM_RST    = 1'b1;
  assign bus.oRAM_ADQ_OE = (state_q == StCmd) || (state_q == StAddr);
  assign bus.oRAM_ADQ    = (state_q == StAddr) ? addr_byte : 8'h00;
  assign oBusy           = (state_q != StIdle);
  assign oUpload_Done    = done_q;

  // ---------------- FIFO and output register ----------------
  assign push      = (state_q == StData);
  assign fifo_head = mem_q[rd_ptr_q];
  assign out_free  = !tx_valid_q || bus.iTx_Ready;

  always_comb begin
    pop        = 1'b0;
    load       = 1'b0;
    load_byte  = 8'h00;
    acc_cnt_d  = acc_cnt_q;
    last_acc_d = last_acc_q;
`ifdef ZDDR_READER_FRAME_HEADER_EN
    phase_d  = phase_q;
    ld_cnt_d = ld_cnt_q;
    sum_d    = sum_q;
    if (out_free) begin
      case (phase_q)
        OutHdr0: begin
          load      = 1'b1;
          load_byte = 8'h55;
          phase_d   = OutHdr1;
        end
        OutHdr1: begin
          load      = 1'b1;
          load_byte = 8'hAA;
          phase_d   = OutData;
        end
        OutData: if (fifo_cnt_q != '0) begin
          load      = 1'b1;
          pop       = 1'b1;
          load_byte = fifo_head;
          ld_cnt_d  = ld_cnt_q + 16'd1;
          sum_d     = sum_q + {8'h00, fifo_head};
          if (ld_cnt_q == 16'(FRAME_BYTES - 1)) phase_d = OutSumHi;
        end
        OutSumHi: begin
          load      = 1'b1;
          load_byte = sum_q[15:8];
          phase_d   = OutSumLo;
        end
        OutSumLo: begin
          load      = 1'b1;
          load_byte = sum_q[7:0];
          phase_d   = OutEnd;
        end
        default: ;
      endcase
    end
    if (frame_start) begin
      phase_d  = OutHdr0;
      ld_cnt_d = '0;
      sum_d    = '0;
    end
`else
    if (out_free && (fifo_cnt_q != '0)) begin
      load      = 1'b1;
      pop       = 1'b1;
      load_byte = fifo_head;
    end
`endif
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = load_byte;
    end else if (bus.iTx_Ready) begin
      tx_valid_d = 1'b0;
    end
    if (tx_valid_q && bus.iTx_Ready) begin
      acc_cnt_d = acc_cnt_q + 16'd1;
      if (acc_cnt_q == 16'(TotalBytes - 1)) last_acc_d = 1'b1;
    end
    if (frame_start) begin
      acc_cnt_d  = '0;
      last_acc_d = 1'b0;
    end
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge iClk) begin
    if (push) mem_q[wr_ptr_q] <= bus.iRAM_ADQ;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      acc_cnt_q  <= '0;
      last_acc_q <= 1'b0;
`ifdef ZDDR_READER_FRAME_HEADER_EN
      phase_q    <= OutEnd;
      ld_cnt_q   <= '0;
      sum_q      <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      acc_cnt_q  <= acc_cnt_d;
      last_acc_q <= last_acc_d;
`ifdef ZDDR_READER_FRAME_HEADER_EN
      phase_q    <= phase_d;
      ld_cnt_q   <= ld_cnt_d;
      sum_q      <= sum_d;
`endif
    end
  end

  assign bus.oTx_Valid = tx_valid_q;
  assign bus.oTx_Data  = tx_data_q;
endmodule

// File: tb/tb_zddr_reader.sv
// Self-checking bench for zddr_reader: PSRAM pad model, Tx collector and a frame-level
// reference built from the address-to-data rule of the PSRAM model.
module tb_zddr_reader;
  localparam int unsigned FrameBytes = 1024;
  localparam logic [31:0] BaseAddr   = 32'h0;
  localparam int unsigned BurstLen   = 32;
  localparam int unsigned Latency    = 5;
  localparam int unsigned FifoDepth  = 64;
  localparam int unsigned CeGap      = 4;
  localparam int unsigned NumBursts  = FrameBytes / BurstLen;
  localparam int unsigned DataPos    = 6 + 2 * Latency;  // first data cycle in a CE-low window
`ifdef ZDDR_READER_FRAME_HEADER_EN
  localparam int HdrBytes = 2;
`else
  localparam int HdrBytes = 0;
`endif

  logic iClk = 1'b0;
  logic iRst, iStart, oBusy, oUpload_Done;
  zddr_reader_if bus ();

  zddr_reader #(
    .FRAME_BYTES(FrameBytes), .BASE_ADDR(BaseAddr), .BURST_LEN(BurstLen),
    .LATENCY(Latency), .FIFO_DEPTH(FifoDepth), .CE_GAP(CeGap)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .oBusy(oBusy),
    .oUpload_Done(oUpload_Done), .bus(bus)
  );

  always #5 iClk = ~iClk;

  int tests = 0;
  int fails = 0;
  logic [7:0] salt = 8'h00;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  // Observations gathered by the models, cleared whenever a frame begins (oBusy rises).
  int win_cnt, gap_err, oe_err, clk_err, addr_err, data_cyc, ce_pos, w1_wait_low;
  logic [7:0] w2_adq [6];
  logic       w2_oe  [6];
  logic [7:0] rx_q [$];
  int done_cnt = 0;
  int done_rx = 0;
  int hold_err = 0;

  function automatic logic [7:0] psram_byte(input logic [31:0] a);
    return a[7:0] ^ salt;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // PSRAM pad model: decodes each CE-low window by position and returns data for the
  // captured address.
  initial begin : psram_model
    int n;
    int hi_run;
    logic [31:0] a;
    logic busy_p;
    n = 0; hi_run = 1000; a = '0; busy_p = 1'b0;
    bus.iRAM_ADQ = 8'h00;
    forever begin
      @(negedge iClk);
      if (oBusy && !busy_p) begin
        win_cnt = 0; gap_err = 0; oe_err = 0; clk_err = 0; addr_err = 0;
        data_cyc = 0; w1_wait_low = 0;
      end
      busy_p = oBusy;
      if (bus.oRAM_CE === 1'b1) begin
        if (n != 0) hi_run = 0;
        n = 0;
        hi_run++;
        ce_pos = -1;
        if (bus.oRAM_CLK !== 1'b0) clk_err++;
        if (bus.oRAM_ADQ_OE !== 1'b0) oe_err++;
        bus.iRAM_ADQ = 8'($urandom);
      end else if (bus.oRAM_CE === 1'b0) begin
        if (n == 0) begin
          if (win_cnt > 0 && hi_run < int'(CeGap)) gap_err++;
          win_cnt++;
        end
        if (bus.oRAM_ADQ_OE !== (n < 6)) oe_err++;
        if (bus.oRAM_CLK !== ((n % 2) == 0)) clk_err++;
        if (n < 2 && bus.oRAM_ADQ !== 8'h00) addr_err++;
        if (n >= 2 && n < 6) a = {a[23:0], bus.oRAM_ADQ};
        if (n == 5 && a !== BaseAddr + 32'(win_cnt - 1) * BurstLen) addr_err++;
        if (win_cnt == 2 && n < 6) begin
          w2_adq[n] = bus.oRAM_ADQ;
          w2_oe[n]  = bus.oRAM_ADQ_OE;
        end
        if (win_cnt == 1 && n >= 6 && n < int'(DataPos) && bus.oRAM_ADQ_OE === 1'b0)
          w1_wait_low++;
        if (n >= int'(DataPos)) begin
          bus.iRAM_ADQ = psram_byte(a + 32'(n - int'(DataPos)));
          data_cyc++;
        end else begin
          bus.iRAM_ADQ = 8'($urandom);
        end
        ce_pos = n;
        n++;
      end
    end
  end

  // Upload consumer: collects accepted bytes, checks hold-while-stalled, counts done pulses.
  initial begin : tx_mon
    logic pv, pr, prst, bp;
    logic [7:0] pd;
    pv = 1'b0; pr = 1'b0; prst = 1'b1; bp = 1'b0; pd = 8'h00;
    forever begin
      @(negedge iClk);
      if (oBusy && !bp) rx_q.delete();
      bp = oBusy;
      if (pv && !pr && !prst && !iRst) begin
        if (bus.oTx_Valid !== 1'b1 || bus.oTx_Data !== pd) hold_err++;
      end
      if (bus.oTx_Valid === 1'b1 && bus.iTx_Ready === 1'b1) rx_q.push_back(bus.oTx_Data);
      if (oUpload_Done === 1'b1) begin
        done_cnt++;
        done_rx = rx_q.size();
      end
      pv = bus.oTx_Valid; pr = bus.iTx_Ready; pd = bus.oTx_Data; prst = iRst;
    end
  end

  initial begin : rdy_drv
    bus.iTx_Ready = 1'b0;
    forever begin
      @(posedge iClk);
      #1;
      case (rdy_mode)
        0: bus.iTx_Ready = 1'b1;
        1: bus.iTx_Ready = ($urandom_range(3) != 0);
        default: bus.iTx_Ready = 1'b0;
      endcase
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(posedge iClk); #1 iStart = 1'b1;
    @(posedge iClk); #1 iStart = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 20000 && done_cnt == d0; i++) @(negedge iClk);
    check("done_seen", (done_cnt != d0), 1);
    repeat (5) @(negedge iClk);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 20000 && rx_q.size() < n; i++) @(negedge iClk);
    check("rx_reached", (rx_q.size() >= n), 1);
  endtask

  // Reference stream for one frame, compared against what the consumer accepted.
  task automatic check_frame(input string tag, input int d0);
    logic [7:0] exp_q [$];
    logic [7:0] b;
    logic [15:0] sum;
    int mism;
    sum = '0;
    mism = 0;
`ifdef ZDDR_READER_FRAME_HEADER_EN
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
`endif
    for (int k = 0; k < int'(FrameBytes); k++) begin
      b = psram_byte(BaseAddr + 32'(k));
      sum = sum + {8'h00, b};
      exp_q.push_back(b);
    end
`ifdef ZDDR_READER_FRAME_HEADER_EN
    exp_q.push_back(sum[15:8]);
    exp_q.push_back(sum[7:0]);
`endif
    for (int k = 0; k < exp_q.size(); k++)
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) mism++;
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    check({tag, "_bad_bytes"}, mism, 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_done_after_last"}, done_rx, exp_q.size());
    check({tag, "_busy_after"}, oBusy, 0);
    check({tag, "_ce_windows"}, win_cnt, NumBursts);
    check({tag, "_data_cycles"}, data_cyc, FrameBytes);
    check({tag, "_gap_err"}, gap_err, 0);
    check({tag, "_oe_err"}, oe_err, 0);
    check({tag, "_clk_err"}, clk_err, 0);
    check({tag, "_addr_err"}, addr_err, 0);
    check({tag, "_hold_err"}, hold_err, 0);
  endtask

  initial begin : main
    int d0;
    int w;
    int level;
    iRst = 1'b1;
    iStart = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_busy", oBusy, 0);
    check("rst_done", oUpload_Done, 0);
    check("rst_ram_clk", bus.oRAM_CLK, 0);
    check("rst_ce", bus.oRAM_CE, 1);
    check("rst_ram_rst", bus.oRAM_RST, 1);
    check("rst_adq", bus.oRAM_ADQ, 0);
    check("rst_oe", bus.oRAM_ADQ_OE, 0);
    check("rst_valid", bus.oTx_Valid, 0);
    check("rst_data", bus.oTx_Data, 0);
    iRst = 1'b0;

    // Basic frame: data = addr[7:0], always ready.
    salt = 8'h00; rdy_mode = 0; d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    check_frame("basic", d0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2_adq%0d", i), w2_adq[i], (i == 5) ? 32'h20 : 32'h0);
      check($sformatf("b2_oe%0d", i), w2_oe[i], 1);
    end
    check("b1_wait_oe_low", w1_wait_low, 2 * Latency);

    // Random data pattern, random backpressure.
    salt = 8'($urandom); rdy_mode = 1; d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    check_frame("random_ready", d0);

    // Long stall mid-frame: reader must stop opening bursts, then resume losslessly.
    salt = 8'($urandom); rdy_mode = 0; d0 = done_cnt;
    pulse_start();
    wait_rx(300);
    rdy_mode = 2;
    repeat (200) @(negedge iClk);
    w = win_cnt;
    repeat (100) @(negedge iClk);
    level = data_cyc - (rx_q.size() - HdrBytes);
    check("bp_no_new_bursts", win_cnt, w);
    check("bp_ce_high", bus.oRAM_CE, 1);
    check("bp_valid_held", bus.oTx_Valid, 1);
    check("bp_fill_level", (level > int'(FifoDepth - BurstLen) && level <= int'(FifoDepth) + 1), 1);
    rdy_mode = 1;
    wait_done(d0);
    check_frame("backpressure", d0);

    // Reset during the data phase of burst 5, then a fresh complete frame.
    salt = 8'($urandom); rdy_mode = 0; d0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 20000 && !(win_cnt == 5 && ce_pos >= int'(DataPos) + 4); i++)
      @(negedge iClk);
    check("rst_reached_b5", (win_cnt == 5 && ce_pos >= int'(DataPos) + 4), 1);
    @(posedge iClk); #1 iRst = 1'b1;
    @(posedge iClk); #1;
    check("midrst_ce", bus.oRAM_CE, 1);
    check("midrst_oe", bus.oRAM_ADQ_OE, 0);
    check("midrst_valid", bus.oTx_Valid, 0);
    check("midrst_busy", oBusy, 0);
    iRst = 1'b0;
    repeat (100) @(negedge iClk);
    check("midrst_no_done", done_cnt, d0);
    salt = 8'($urandom); d0 = done_cnt;
    pulse_start();
    wait_done(d0);
    check_frame("after_reset", d0);

    // A second start mid-frame must be ignored.
    salt = 8'($urandom); rdy_mode = 1; d0 = done_cnt;
    pulse_start();
    wait_rx(500 + HdrBytes);
    pulse_start();
    wait_done(d0);
    check_frame("start_busy", d0);
    repeat (200) @(negedge iClk);
    check("start_busy_no_refire", done_cnt - d0, 1);
    check("start_busy_idle", oBusy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
